// File: rtl/riscv_v_pkg.sv
// Shared types for the riscv_v elastic pipeline stages.
// Latency: none, this file holds declarations only.
// Backpressure: none, this file holds declarations only.
package riscv_v_pkg;

    // Encoding is chosen so that the state value equals the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/riscv_v_skid_stage.sv
// Two-entry skid buffer that cuts the ready path between upstream and downstream.
// Latency: 1 cycle from input accept to out_data when empty, or when busy and draining.
// Backpressure: in_ready is registered and drops only when both entries are held.
module riscv_v_skid_stage
    import riscv_v_pkg::*;
#(
    parameter int unsigned          DATA_W  = 32,
    parameter logic [DATA_W-1:0]    RST_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          occupancy
);

    skid_state_e        state_q, state_d;
    logic [DATA_W-1:0]  main_q, main_d;
    logic [DATA_W-1:0]  skid_q, skid_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               in_fire;
    logic               out_fire;

    // Handshakes use only registered ready/valid, so out_ready never reaches in_ready.
    assign in_fire  = in_valid && in_ready_q && !flush;
    assign out_fire = out_valid_q && out_ready;

    // State and data registers; reset empties the stage immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= RST_VAL;
            skid_q      <= RST_VAL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic; flush overrides every transfer and drops all entries.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (in_fire && !out_fire)      state_d = ST_FULL;
                else if (!in_fire && out_fire) state_d = ST_EMPTY;
            end
            ST_FULL: begin
                if (out_fire) state_d = ST_BUSY;
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) state_d = ST_EMPTY;
    end

    // Data register loads; registers hold otherwise so idle storage does not toggle.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (!flush) begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) main_d = in_data;
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) main_d = in_data;
                    else if (in_fire)        skid_d = in_data;
                end
                ST_FULL: begin
                    if (out_fire) main_d = skid_q;
                end
                default: begin
                    main_d = main_q;
                    skid_d = skid_q;
                end
            endcase
        end
    end

    // Handshake outputs are precomputed from the next state so they leave flops directly.
    always_comb begin
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = state_q;

endmodule

// File: tb/tb_riscv_v_skid_stage.sv
// Self-checking bench for riscv_v_skid_stage against a queue model.
// Latency: model updates on each rising edge, outputs compared on falling edges.
// Backpressure: model accepts input only while it holds fewer than two entries.
module tb_riscv_v_skid_stage;

    localparam int unsigned       DATA_W  = 32;
    localparam logic [DATA_W-1:0] RST_VAL = 32'h0000_00A5;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] model_q[$];

    riscv_v_skid_stage #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of at most two entries, cleared by flush or reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q.delete();
        end else if (flush) begin
            model_q.delete();
        end else begin
            automatic bit can_take = (model_q.size() < 2);
            if (model_q.size() > 0 && out_ready) void'(model_q.pop_front());
            if (in_valid && can_take) model_q.push_back(in_data);
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("occupancy", 64'(occupancy), 64'(model_q.size()));
            chk("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
            chk("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
            if (model_q.size() > 0) chk("out_data", 64'(out_data), 64'(model_q[0]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'h0000_00A5);
        rst = 1'b0;

        // Streaming at full rate: each entry visible one edge after it was accepted.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(i);
            step();
            chk("stream_data", 64'(out_data), 64'(i));
            chk("stream_occ", 64'(occupancy), 64'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drain", 64'(out_valid), 64'd0);

        // Backpressure: two entries fill the stage, the third waits upstream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        step();
        in_data   = 32'hB;
        step();
        chk("bp_occ", 64'(occupancy), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        in_data   = 32'hC;
        step();
        chk("bp_hold_data", 64'(out_data), 64'hA);
        chk("bp_hold_occ", 64'(occupancy), 64'd2);
        out_ready = 1'b1;
        step();
        chk("bp_out_b", 64'(out_data), 64'hB);
        chk("bp_occ_b", 64'(occupancy), 64'd1);
        step();
        chk("bp_out_c", 64'(out_data), 64'hC);
        chk("bp_occ_c", 64'(occupancy), 64'd1);
        in_valid = 1'b0;
        step();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Flush while full, with a new entry offered in the same cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        in_data   = 32'h22;
        step();
        chk("fl_pre_occ", 64'(occupancy), 64'd2);
        in_data   = 32'h5;
        flush     = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        chk("fl_occ", 64'(occupancy), 64'd0);
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step();
        chk("fl_no_five", 64'(out_valid), 64'd0);

        // First edge after a flush must accept input.
        in_valid = 1'b1;
        in_data  = 32'h77;
        step();
        chk("post_fl_data", 64'(out_data), 64'h77);
        in_valid = 1'b0;
        step();

        // Reset asserted mid-cycle with two entries held clears everything at once.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h33;
        step();
        in_data   = 32'h44;
        step();
        in_valid  = 1'b0;
        chk("mr_pre_occ", 64'(occupancy), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_occ", 64'(occupancy), 64'd0);
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_in_ready", 64'(in_ready), 64'd1);
        chk("mr_out_data", 64'(out_data), 64'h0000_00A5);
        step();
        rst = 1'b0;

        // Random traffic checked by the per-cycle compare process.
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = $urandom();
            flush     = ($urandom_range(0, 199) == 0);
            step();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("final_empty", 64'(occupancy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_v_skid_stage.md
RISCV_V_SKID_STAGE -- requirements
Module: riscv_v_skid_stage

Interface
REQ-001 Parameter DATA_W, default 32, payload width in bits.
REQ-002 Parameter RST_VAL, default 0, value (DATA_W bits) loaded into both data registers on reset.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  synchronous flush, discards all held entries.
REQ-006 in_valid  input  1  upstream offers in_data.
REQ-007 in_ready  output  1  stage can accept an entry this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 out_valid  output  1  out_data holds a valid entry.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  DATA_W  payload of the oldest held entry.
REQ-012 occupancy  output  2  number of held entries, 0..2.

Function
REQ-013 Input transfer (in_fire) SHALL occur when in_valid && in_ready && !flush.
REQ-014 Output transfer (out_fire) SHALL occur when out_valid && out_ready.
REQ-015 Storage SHALL be two DATA_W registers: main (drives out_data) and skid.
REQ-016 The FSM SHALL have states EMPTY (0 entries), BUSY (main valid), FULL (main and skid valid), encoded so that occupancy equals the state count.
REQ-017 in_ready SHALL equal (state != FULL), driven from a register, with no combinational path from out_ready.
REQ-018 out_valid SHALL equal (state != EMPTY), driven from a register.
REQ-019 EMPTY: in_fire -> main <= in_data, go to BUSY; otherwise stay.
REQ-020 BUSY: in_fire and out_fire -> main <= in_data, stay BUSY; in_fire only -> skid <= in_data, go to FULL; out_fire only -> go to EMPTY; neither -> stay.
REQ-021 FULL: out_fire -> main <= skid, go to BUSY; otherwise stay. No input is accepted.
REQ-022 Latency SHALL be exactly 1 cycle from in_fire to the entry appearing on out_data when the stage was EMPTY, or when it was BUSY with out_fire in the same cycle.
REQ-023 Throughput SHALL be one entry per cycle when out_ready is held high.
REQ-024 Order SHALL be strictly FIFO; no entry may be duplicated or dropped except by flush or rst.
REQ-025 While out_valid && !out_ready, out_data SHALL remain stable.
REQ-026 flush SHALL force state to EMPTY on the next edge, regardless of in_valid/out_ready. Any in_data offered in that cycle is discarded. Data registers hold their values.
REQ-027 An out_fire in a flush cycle SHALL be counted as consumed downstream. The stage takes no further action for it.
REQ-028 Data registers SHALL load only on the events listed in REQ-019..021, so unused registers do not toggle.

Reset
REQ-029 On rst, state SHALL be EMPTY, in_ready=1, out_valid=0, occupancy=0, and main=skid=RST_VAL.
REQ-030 rst SHALL take priority over flush and over all transfers.
REQ-031 Deassertion SHALL be synchronised externally; the first edge after deassertion SHALL accept input.
REQ-032 Reset asserted mid-operation SHALL discard all entries immediately (asynchronously).

Structure
REQ-033 The state enum (EMPTY/BUSY/FULL) SHALL reside in the shared riscv_v package for reuse by other elastic stages.
REQ-034 The block SHALL be flat with no sub-modules. A chain of N stages SHALL be built by instantiating riscv_v_skid_stage N times.
REQ-035 The block SHALL contain no latches, and every output SHALL be either a register or a single gate from a register.

Verification
REQ-036 Reset: assert rst mid-stream with occupancy=2 -> occupancy=0, out_valid=0, in_ready=1, out_data=RST_VAL immediately.
REQ-037 Streaming: out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 on the following consecutive cycles, occupancy constant at 1.
REQ-038 Backpressure: send 0xA then 0xB with out_ready=0 -> occupancy=2, in_ready=0, and 0xC is held upstream. Then raise out_ready -> outputs 0xA, 0xB, 0xC in order, with no loss.
REQ-039 Flush: occupancy=2 and in_valid=1 with 0x5 offered, pulse flush -> next cycle occupancy=0, out_valid=0, and 0x5 never appears on the output.
REQ-040 Random: random in_valid/out_ready over 10k cycles against a scoreboard -> exact FIFO order, occupancy<=2, out_data stable during stalls.
